// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART byte receiver: one-hot state encodings,
// default bit timing and frame width.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int DATA_BITS            = 8;

   typedef enum logic [5:0] {
      IDLE   = 6'b000001,
      START  = 6'b000010,
      DATA   = 6'b000100,
      PARITY = 6'b001000,
      STOP   = 6'b010000,
      BREAK  = 6'b100000
   } rxState_t;

   // Even parity holds when the data bits plus the parity bit contain an even number of ones
   function automatic logic evenParityOk(input logic [DATA_BITS-1:0] data, input logic parityBit);
      return ~(^data ^ parityBit);
   endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte-strobe bundle from the UART receiver to the character-input block;
// the receiver drives the master side.
interface uart_rx_byte_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] RX_DATA;
   logic                 RX_VALID;
   logic                 FRAME_ERR;
   logic                 BUSY;

   modport master (output RX_DATA, output RX_VALID, output FRAME_ERR, output BUSY);
   modport slave  (input  RX_DATA, input  RX_VALID, input  FRAME_ERR, input  BUSY);

endinterface

// File: rtl/uart_rx_byte_sync.sv
// Two-flop synchroniser for a single asynchronous pin; the reset value is a
// parameter so idle-high lines do not glitch low out of reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic stage1_q;
   logic stage2_q;

   // Only stage2_q is safe to consume; stage1_q may be metastable
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage1_q <= RESET_VAL;
         stage2_q <= RESET_VAL;
      end else begin
         stage1_q <= d_i;
         stage2_q <= stage1_q;
      end
   end

   assign q_o = stage2_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, producing one-cycle byte and framing-error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           rx,
   uart_rx_byte_if.master rxIf
);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

   logic                 rxSync;
   rxState_t             state_q;
   logic [CNT_W-1:0]     timer_q;
   logic [2:0]           bitIdx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] rxData_q;
   logic                 rxValid_q;
   logic                 frameErr_q;
`ifdef UART_RX_PARITY_EN
   logic                 parErr_q;
`endif

   sync_2ff #(.RESET_VAL(1'b1)) uRxSync (
      .clock (clock),
      .reset (reset),
      .d_i   (rx),
      .q_o   (rxSync)
   );

   // Frame FSM: bit timer restarts at each sample so every later sample lands mid-bit,
   // and both strobes default low so each lasts exactly one cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         rxData_q   <= '0;
         rxValid_q  <= 1'b0;
         frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parErr_q   <= 1'b0;
`endif
      end else begin
         rxValid_q  <= 1'b0;
         frameErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               timer_q <= '0;
               if (!rxSync) state_q <= START;
            end
            START: begin
               if (timer_q == HALF_LAST) begin
                  timer_q  <= '0;
                  bitIdx_q <= '0;
                  state_q  <= rxSync ? IDLE : DATA;
               end else begin
                  timer_q <= timer_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (timer_q == BIT_LAST) begin
                  timer_q           <= '0;
                  shift_q[bitIdx_q] <= rxSync;
                  bitIdx_q          <= bitIdx_q + 3'd1;
                  if (bitIdx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end else begin
                  timer_q <= timer_q + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (timer_q == BIT_LAST) begin
                  timer_q  <= '0;
                  parErr_q <= ~evenParityOk(shift_q, rxSync);
                  state_q  <= STOP;
               end else begin
                  timer_q <= timer_q + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  if (rxSync) begin
                     state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                     if (parErr_q) begin
                        frameErr_q <= 1'b1;
                     end else begin
                        rxData_q  <= shift_q;
                        rxValid_q <= 1'b1;
                     end
`else
                     rxData_q  <= shift_q;
                     rxValid_q <= 1'b1;
`endif
                  end else begin
                     frameErr_q <= 1'b1;
                     state_q    <= BREAK;
                  end
               end else begin
                  timer_q <= timer_q + CNT_W'(1);
               end
            end
            BREAK: begin
               timer_q <= '0;
               if (rxSync) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               timer_q <= '0;
            end
         endcase
      end
   end

   assign rxIf.RX_DATA   = rxData_q;
   assign rxIf.RX_VALID  = rxValid_q;
   assign rxIf.FRAME_ERR = frameErr_q;
   assign rxIf.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit: clean frames, false start,
// framing error with line break, mid-frame reset, skewed line rates, optional parity.
module tb_uart_rx_byte;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;
   localparam int LAT_MAX   = 155 + (NBITS - 10) * CPB;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic rx    = 1'b1;

   uart_rx_byte_if rxIf ();

   uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
      .clock (clock),
      .reset (reset),
      .rx    (rx),
      .rxIf  (rxIf)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   int validCount = 0;
   int ferrCount = 0;
   int bothHigh = 0;
   bit busySeen = 1'b0;
   int validCycQ[$];
   logic [7:0] validDataQ[$];
   int total = 0;
   int bad = 0;

   always @(posedge clock) cyc++;

   // Record every strobe seen on the falling edge, away from the DUT's active edge
   always @(negedge clock) begin
      if (!reset) begin
         if (rxIf.RX_VALID) begin
            validCount++;
            validCycQ.push_back(cyc);
            validDataQ.push_back(rxIf.RX_DATA);
         end
         if (rxIf.FRAME_ERR) ferrCount++;
         if (rxIf.RX_VALID && rxIf.FRAME_ERR) bothHigh++;
         if (rxIf.BUSY) busySeen = 1'b1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [10:0] mkFrame(input logic [7:0] data, input logic stopVal);
      logic [10:0] f;
      f = '1;
      f[0]   = 1'b0;
      f[8:1] = data;
`ifdef UART_RX_PARITY_EN
      f[9]  = ^data;
      f[10] = stopVal;
`else
      f[9]  = stopVal;
`endif
      return f;
   endfunction

   // Bit boundaries land at floor((k+1)*halfPer/2) cycles, allowing half-clock line rates
   task automatic applyStimulus(input logic [10:0] frameBits, input int halfPer);
      int t;
      t = 0;
      for (int k = 0; k < NBITS; k++) begin
         rx = frameBits[k];
         while (t < ((k + 1) * halfPer) / 2) begin
            @(negedge clock);
            t++;
         end
      end
   endtask

   int v0, f0, q0, fallCyc;

   initial begin
      repeat (3) @(negedge clock);
      checkOutput("reset RX_DATA", 32'(rxIf.RX_DATA), 32'h00);
      checkOutput("reset RX_VALID", 32'(rxIf.RX_VALID), 32'h0);
      checkOutput("reset FRAME_ERR", 32'(rxIf.FRAME_ERR), 32'h0);
      checkOutput("reset BUSY", 32'(rxIf.BUSY), 32'h0);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      // Two frames back to back with no idle gap
      v0 = validCount; f0 = ferrCount; q0 = validCycQ.size();
      fallCyc = cyc;
      applyStimulus(mkFrame(8'h55, 1'b1), 2 * CPB);
      applyStimulus(mkFrame(8'hA3, 1'b1), 2 * CPB);
      repeat (40) @(negedge clock);
      checkOutput("b2b count", 32'(validCount - v0), 32'd2);
      if (validCycQ.size() >= q0 + 2) begin
         checkOutput("b2b first data", 32'(validDataQ[q0]), 32'h55);
         checkOutput("b2b second data", 32'(validDataQ[q0 + 1]), 32'hA3);
         checkOutput("b2b spacing", 32'(validCycQ[q0 + 1] - validCycQ[q0]), 32'(FRAME_CYC));
         checkOutput("latency window",
                     32'((validCycQ[q0] - fallCyc >= LAT_MAX - 2) && (validCycQ[q0] - fallCyc <= LAT_MAX)), 32'd1);
      end
      checkOutput("b2b no frame err", 32'(ferrCount - f0), 32'd0);

      // False start: a 5-cycle low glitch is rejected at the mid-start sample
      v0 = validCount; f0 = ferrCount;
      busySeen = 1'b0;
      rx = 1'b0;
      repeat (5) @(negedge clock);
      rx = 1'b1;
      repeat (30) @(negedge clock);
      checkOutput("glitch busy seen", 32'(busySeen), 32'd1);
      checkOutput("glitch back idle", 32'(rxIf.BUSY), 32'd0);
      checkOutput("glitch no valid", 32'(validCount - v0), 32'd0);
      checkOutput("glitch no ferr", 32'(ferrCount - f0), 32'd0);

      // Bad stop bit followed by a long break, then a good frame
      v0 = validCount; f0 = ferrCount;
      applyStimulus(mkFrame(8'h3C, 1'b0), 2 * CPB);
      repeat (100) @(negedge clock);
      checkOutput("break ferr once", 32'(ferrCount - f0), 32'd1);
      checkOutput("break no valid", 32'(validCount - v0), 32'd0);
      checkOutput("break data held", 32'(rxIf.RX_DATA), 32'hA3);
      checkOutput("break busy", 32'(rxIf.BUSY), 32'd1);
      rx = 1'b1;
      repeat (20) @(negedge clock);
      applyStimulus(mkFrame(8'h81, 1'b1), 2 * CPB);
      repeat (40) @(negedge clock);
      checkOutput("after break valid", 32'(validCount - v0), 32'd1);
      checkOutput("after break data", 32'(rxIf.RX_DATA), 32'h81);
      checkOutput("after break ferr", 32'(ferrCount - f0), 32'd1);

      // Reset in the middle of data bit 3 of 0xFF
      v0 = validCount;
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
      repeat (3 * CPB + CPB / 2) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("mid reset RX_DATA", 32'(rxIf.RX_DATA), 32'h00);
      checkOutput("mid reset RX_VALID", 32'(rxIf.RX_VALID), 32'h0);
      checkOutput("mid reset FRAME_ERR", 32'(rxIf.FRAME_ERR), 32'h0);
      checkOutput("mid reset BUSY", 32'(rxIf.BUSY), 32'h0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (200) @(negedge clock);
      checkOutput("no strobe for 0xFF", 32'(validCount - v0), 32'd0);
      applyStimulus(mkFrame(8'h12, 1'b1), 2 * CPB);
      repeat (40) @(negedge clock);
      checkOutput("post reset valid", 32'(validCount - v0), 32'd1);
      checkOutput("post reset data", 32'(rxIf.RX_DATA), 32'h12);

      // Line rates about 3% slow and fast (15.5 and 16.5 clocks per bit); a whole
      // clock of error per bit at 16 clocks/bit exceeds the mid-bit sampling margin
      v0 = validCount;
      applyStimulus(mkFrame(8'h7E, 1'b1), 2 * CPB - 1);
      repeat (40) @(negedge clock);
      checkOutput("fast rate valid", 32'(validCount - v0), 32'd1);
      checkOutput("fast rate data", 32'(rxIf.RX_DATA), 32'h7E);
      applyStimulus(mkFrame(8'h00, 1'b1), 2 * CPB);
      repeat (20) @(negedge clock);
      v0 = validCount;
      applyStimulus(mkFrame(8'h7E, 1'b1), 2 * CPB + 1);
      repeat (40) @(negedge clock);
      checkOutput("slow rate valid", 32'(validCount - v0), 32'd1);
      checkOutput("slow rate data", 32'(rxIf.RX_DATA), 32'h7E);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: parity 1 is even (accepted), parity 0 is odd (rejected)
      v0 = validCount; f0 = ferrCount;
      applyStimulus(11'b1_1_00000111_0, 2 * CPB);
      repeat (20) @(negedge clock);
      checkOutput("parity good valid", 32'(validCount - v0), 32'd1);
      checkOutput("parity good data", 32'(rxIf.RX_DATA), 32'h07);
      checkOutput("parity good ferr", 32'(ferrCount - f0), 32'd0);
      applyStimulus(11'b1_0_00000111_0, 2 * CPB);
      repeat (40) @(negedge clock);
      checkOutput("parity bad valid", 32'(validCount - v0), 32'd1);
      checkOutput("parity bad ferr", 32'(ferrCount - f0), 32'd1);
      checkOutput("parity bad idle", 32'(rxIf.BUSY), 32'd0);
`endif

      checkOutput("valid and ferr exclusive", 32'(bothHigh), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
